// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants, FSM and ALU enums, legality decode for multicycle_cpu
package cpu_pkg;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_D    = 3'b011;
  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
  function automatic logic legal(input logic [31:0] ir);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = ir[6:0];
    f3 = ir[14:12];
    f7 = ir[31:25];
    return (op == OP_R && f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) ||
           (op == OP_R && f7 == F7_ADD && (f3 == F3_OR || f3 == F3_AND)) ||
           (op == OP_ADDI && f3 == F3_ADD) ||
           ((op == OP_LD || op == OP_SD) && f3 == F3_D) ||
           (op == OP_BEQ && f3 == F3_ADD);
  endfunction
endpackage

// File: rtl/regfile_mc.sv
// regfile_mc: NREGS x XLEN register file, two async reads, one sync write, x0 hardwired zero
module regfile_mc #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic                     we,
  input  logic [XLEN-1:0]          wd,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2
);
  logic [XLEN-1:0] regs [NREGS];
  always_ff @(posedge clk) begin
    if (reset) regs <= '{default: '0};
    else if (we && wa != '0) regs[wa] <= wd;
  end
  assign rd1 = ra1 == '0 ? '0 : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : regs[ra2];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FSM-sequenced RV64I-subset core with req/ack instruction and data memories
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retired,
  output logic            halted
);
  localparam int AW = $clog2(NREGS);
  state_t          state, state_n;
  alu_op_t         alu_op;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc, a, b, alu_r, mdr, imm, src2, alu_y, rd1, rd2;
  logic [6:0]      opcode;
  logic            is_beq, is_sd, is_mem;
  assign opcode = ir[6:0];
  assign is_beq = opcode == OP_BEQ;
  assign is_sd  = opcode == OP_SD;
  assign is_mem = opcode == OP_LD || is_sd;
  assign imm = is_sd  ? {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]} :
               is_beq ? {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                        {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign alu_op = opcode != OP_R        ? ALU_ADD :
                  ir[14:12] == F3_OR    ? ALU_OR  :
                  ir[14:12] == F3_AND   ? ALU_AND :
                  ir[31:25] == F7_SUB   ? ALU_SUB : ALU_ADD;
  assign src2  = opcode == OP_R ? b : imm;
  assign alu_y = alu_op == ALU_SUB ? a - src2 :
                 alu_op == ALU_AND ? a & src2 :
                 alu_op == ALU_OR  ? a | src2 : a + src2;
  regfile_mc #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk, .reset,
    .ra1(ir[15 +: AW]), .ra2(ir[20 +: AW]), .wa(ir[7 +: AW]),
    .we(state == WB), .wd(opcode == OP_LD ? mdr : alu_r),
    .rd1, .rd2
  );
  always_comb begin
    state_n = state;
    state_n = state == FETCH  ? (pc[1:0] != 2'b00 ? HALT : imem_ack ? DECODE : FETCH) :
              state == DECODE ? (legal(ir) ? EXEC : HALT) :
              state == EXEC   ? (is_beq ? FETCH : is_mem ? MEM : WB) :
              state == MEM    ? (dmem_ack ? (is_sd ? FETCH : WB) : MEM) :
              state == WB     ? FETCH : HALT;
  end
  // Gating with reset keeps the fetch request low while reset is held in FETCH.
  assign imem_req   = state == FETCH && pc[1:0] == 2'b00 && !reset;
  assign imem_addr  = pc;
  assign dmem_req   = state == MEM;
  assign dmem_we    = state == MEM && is_sd;
  assign dmem_addr  = alu_r;
  assign dmem_wdata = b;
  assign retired    = (state == EXEC && is_beq) || (state == MEM && dmem_ack && is_sd) || state == WB;
  assign halted     = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      alu_r <= '0;
      mdr   <= '0;
    end else begin
      state <= state_n;
      if (imem_req && imem_ack) ir <= imem_rdata;
      if (state == DECODE) begin
        a <= rd1;
        b <= rd2;
      end
      if (state == EXEC) alu_r <= alu_y;
      if (state == EXEC && is_beq) pc <= a == b ? pc + imm : pc + XLEN'(4);
      if (state == MEM && dmem_ack) mdr <= dmem_rdata;
      if ((state == MEM && dmem_ack && is_sd) || state == WB) pc <= pc + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs with retire/store scoreboards and wait-state memory models
module tb_multicycle_cpu;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retired, halted;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] imem_rdata;
  int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic        dack_force = 1'b0;
  logic [31:0] imem [0:63];
  logic [63:0] dmem [0:15];
  multicycle_cpu dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .retired(retired), .halted(halted)
  );
  assign imem_rdata = imem[imem_addr[7:2]];
  assign imem_ack   = imem_req && icnt >= iwait;
  assign dmem_rdata = dmem[dmem_addr[6:3]];
  assign dmem_ack   = (dmem_req && dcnt >= dwait) || dack_force;
  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[6:3]] <= dmem_wdata;
  end

  logic        r32 = 1'b1;
  logic        i32_req, i32_ack, d32_req, d32_we, d32_ack, ret32, halted32;
  logic [31:0] i32_addr, i32_rdata, d32_addr, d32_wdata;
  logic [31:0] imem32 [0:63];
  multicycle_cpu #(.XLEN(32)) u32 (
    .clk(clk), .reset(r32),
    .imem_req(i32_req), .imem_addr(i32_addr), .imem_ack(i32_ack), .imem_rdata(i32_rdata),
    .dmem_req(d32_req), .dmem_we(d32_we), .dmem_addr(d32_addr), .dmem_wdata(d32_wdata),
    .dmem_ack(d32_ack), .dmem_rdata(32'h0), .retired(ret32), .halted(halted32)
  );
  assign i32_rdata = imem32[i32_addr[7:2]];
  assign i32_ack   = i32_req;
  assign d32_ack   = d32_req;

  typedef struct { logic [63:0] pc; int lat; } ret_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; } st_t;
  ret_t rq[$];
  st_t  sq[$], sq32[$];
  int   errors = 0, checks = 0, fill = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output with no expected entry queued", name);
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] rtype(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] ld(input int rd, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'(rs1), 3'b011, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sd(input int rs2, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b011, i[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(input int rs1, input int rs2, input int imm);
    logic [12:0] o;
    o = 13'(imm);
    return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic clear_prog();
    foreach (imem[i]) imem[i] = 32'h0;
    fill = 0;
  endtask
  task automatic p(input logic [31:0] w);
    imem[fill] = w;
    fill++;
  endtask
  task automatic er(input logic [63:0] pc, input int lat);
    ret_t r;
    r.pc = pc;
    r.lat = lat;
    rq.push_back(r);
  endtask
  task automatic es(input logic [63:0] addr, input logic [63:0] data);
    st_t s;
    s.addr = addr;
    s.data = data;
    sq.push_back(s);
  endtask

  task automatic start();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({imem_req, dmem_req, dmem_we, retired, halted}), 64'h0);
    chk("reset_pc", imem_addr, 64'h0);
    chk("reset_dmem_outs", dmem_addr | dmem_wdata, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("halted", 64'(halted), 64'h1);
    repeat (3) begin
      @(negedge clk);
      chk("no_fetch_after_halt", 64'(imem_req), 64'h0);
    end
    chk("retire_queue_drained", 64'(rq.size()), 64'h0);
    chk("store_queue_drained", 64'(sq.size()), 64'h0);
  endtask

  int cyc = 0, last = 0, run = 0;
  logic stable = 1'b1;
  logic [63:0] pa, pw;
  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      last = 0;
      run = 0;
    end else begin
      cyc++;
      if (retired) begin
        if (rq.size() == 0) miss("retire");
        else begin
          ret_t r;
          r = rq.pop_front();
          chk("retire_pc", imem_addr, r.pc);
          chk("retire_latency", 64'(cyc - last), 64'(r.lat));
        end
        last = cyc;
      end
      if (dmem_req) begin
        if (run == 0) stable = 1'b1;
        else if (dmem_addr !== pa || dmem_wdata !== pw) stable = 1'b0;
        pa = dmem_addr;
        pw = dmem_wdata;
        run++;
        if (dmem_ack) begin
          chk("dmem_req_hold", 64'(run), 64'(dwait + 1));
          chk("dmem_stable", 64'(stable), 64'h1);
          if (dmem_we) begin
            if (sq.size() == 0) miss("store");
            else begin
              st_t s;
              s = sq.pop_front();
              chk("store_addr", dmem_addr, s.addr);
              chk("store_data", dmem_wdata, s.data);
            end
          end
          run = 0;
        end
      end else run = 0;
    end
  end
  always @(negedge clk) begin
    if (!r32 && d32_req && d32_ack && d32_we) begin
      if (sq32.size() == 0) miss("store32");
      else begin
        st_t s;
        s = sq32.pop_front();
        chk("store32_addr", 64'(d32_addr), s.addr);
        chk("store32_data", 64'(d32_wdata), s.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Zero-wait ALU program, results observed through stores
    clear_prog();
    p(addi(1, 0, 5)); p(addi(2, 0, 7)); p(rtype(0, 0, 3, 1, 2)); p(rtype(32, 0, 4, 2, 1));
    p(sd(3, 0, 0)); p(sd(4, 0, 8)); p(rtype(0, 6, 5, 1, 2)); p(rtype(0, 7, 6, 1, 2));
    p(sd(5, 0, 16)); p(sd(6, 0, 24)); p(32'hFFFF_FFFF);
    er(0, 4); er(4, 4); er(8, 4); er(12, 4); er(16, 4); er(20, 4);
    er(24, 4); er(28, 4); er(32, 4); er(36, 4);
    es(0, 12); es(8, 2); es(16, 7); es(24, 5);
    iwait = 0; dwait = 0;
    start();
    wait_halt();
    // Store then load with two data wait states
    clear_prog();
    p(addi(1, 0, 5)); p(addi(2, 0, 7)); p(rtype(0, 0, 3, 1, 2)); p(sd(3, 0, 8));
    p(ld(5, 0, 8)); p(sd(5, 0, 16)); p(32'hFFFF_FFFF);
    er(0, 4); er(4, 4); er(8, 4); er(12, 6); er(16, 7); er(20, 6);
    es(8, 12); es(16, 12);
    dwait = 2;
    start();
    wait_halt();
    // Branches, x0 writes, negative immediate, misaligned branch target
    clear_prog();
    p(addi(1, 0, 5)); p(addi(2, 0, 7)); p(beq(1, 1, 8)); p(addi(3, 0, 1));
    p(beq(1, 2, 8)); p(sd(3, 0, 0)); p(addi(0, 0, 9)); p(sd(0, 0, 8));
    p(addi(6, 0, -3)); p(sd(6, 0, 16)); p(beq(0, 0, 2));
    er(0, 4); er(4, 4); er(8, 3); er(16, 3); er(20, 4); er(24, 4);
    er(28, 4); er(32, 4); er(36, 4); er(40, 3);
    es(0, 0); es(8, 0); es(16, 64'hFFFF_FFFF_FFFF_FFFD);
    dwait = 0;
    start();
    wait_halt();
    // Reset in the middle of a load; a late data ack must be ignored
    clear_prog();
    p(addi(5, 0, 3)); p(ld(5, 0, 0));
    dmem[0] = 64'd99;
    er(0, 4);
    dwait = 20;
    start();
    begin
      int n = 0;
      while (!dmem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("load_reached_mem", 64'(dmem_req), 64'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_drops_dmem_req", 64'(dmem_req), 64'h0);
    chk("reset_mid_pc", imem_addr, 64'h0);
    clear_prog();
    p(sd(5, 0, 0)); p(32'hFFFF_FFFF);
    er(0, 5);
    es(0, 0);
    iwait = 1; dwait = 0;
    reset = 1'b0;
    dack_force = 1'b1;
    @(posedge clk);
    #1 dack_force = 1'b0;
    chk("late_ack_ignored_fetching", 64'({dmem_req, halted}), 64'h0);
    wait_halt();
    // Reset out of HALT restores the core
    start();
    chk("halt_cleared", 64'(halted), 64'h0);
    reset = 1'b1;
    rq.delete();
    sq.delete();
    // 32-bit build
    foreach (imem32[i]) imem32[i] = 32'h0;
    imem32[0] = addi(1, 0, -1);
    imem32[1] = rtype(0, 0, 2, 1, 1);
    imem32[2] = addi(0, 0, 9);
    imem32[3] = sd(2, 0, 0);
    imem32[4] = sd(0, 0, 4);
    imem32[5] = 32'hFFFF_FFFF;
    begin
      st_t s;
      s.addr = 0; s.data = 64'hFFFF_FFFE; sq32.push_back(s);
      s.addr = 4; s.data = 0;             sq32.push_back(s);
    end
    repeat (2) @(posedge clk);
    #1 r32 = 1'b0;
    begin
      int n = 0;
      while (!halted32 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("halted32", 64'(halted32), 64'h1);
    chk("store32_queue_drained", 64'(sq32.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
